// File: rtl/clock_switch_pkg.sv
// clock_switch_pkg: shared state encoding and select helpers for the clock switch
package clock_switch_pkg;
  typedef enum logic [1:0] {IDLE, OFF_WAIT, ON_WAIT, ERR} state_t;
  function automatic int unsigned sel_clamp(input int unsigned sel, input int unsigned n_clk);
    return (sel >= n_clk) ? n_clk - 1 : sel;
  endfunction
  function automatic logic [7:0] onehot(input int unsigned sel);
    return 8'(1) << sel;
  endfunction
endpackage

// File: rtl/clock_switch_sync_bus.sv
// clock_switch_sync_bus: WIDTH-bit, STAGES-deep synchroniser with sync reset
module clock_switch_sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [STAGES-1:0][WIDTH-1:0] ff_q;
  // shift the asynchronous bus through the flop chain
  always_ff @(posedge clk) begin
    if (rst) ff_q <= '0;
    else ff_q <= {ff_q[STAGES-2:0], d_i};
  end
  assign q_o = ff_q[STAGES-1];
endmodule

// File: rtl/clock_switch_ctrl.sv
// clock_switch_ctrl: break-before-make N-source clock switch sequencer
module clock_switch_ctrl import clock_switch_pkg::*; #(
  parameter int N_CLK       = 3,
  parameter int SEL_W       = 2,
  parameter int DEF_SEL     = 0,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             rst_clk,
  input  logic [SEL_W-1:0] sel_req,
  input  logic             sel_valid,
  output logic             sel_ready,
  output logic [N_CLK-1:0] en_out,
  input  logic [N_CLK-1:0] en_ack,
  output logic [SEL_W-1:0] cur_sel,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  input  logic             err_clr,
  input  logic             dc_scan_mode
);
  logic [N_CLK-1:0] ack_s, en_q, en_d;
  logic [SEL_W-1:0] cur_q, cur_d, tgt_q, tgt_d, req_sel;
  logic [TO_W-1:0]  cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic             done_q, done_d, err_q, err_d;
  logic             waiting, stuck, to, accept;

  clock_switch_sync_bus #(.WIDTH(N_CLK), .STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst_clk),
    .d_i(en_ack),
    .q_o(ack_s)
  );

  assign req_sel   = SEL_W'(sel_clamp(32'(sel_req), N_CLK));
  assign waiting   = (state_q == OFF_WAIT) || (state_q == ON_WAIT);
  assign stuck     = (state_q == OFF_WAIT) ? |ack_s : (state_q == ON_WAIT) && !ack_s[cur_q];
  assign to        = stuck && (cnt_q == TO_W'(TIMEOUT - 1));
  assign sel_ready = ((state_q == IDLE) || (state_q == ERR)) && !dc_scan_mode;
  assign accept    = sel_valid && sel_ready;
  assign busy      = waiting;
  assign en_out    = en_q;
  assign cur_sel   = cur_q;
  assign done      = done_q;
  assign timeout_err = err_q;

  // next-state: ERR retries always restart the full off/on sequence, and an
  // OFF_WAIT timeout proceeds anyway since the old gate is already commanded off
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    if ((state_q == IDLE) || (state_q == ERR)) begin
      if (accept && (state_q == IDLE) && (req_sel == cur_q)) done_d = 1'b1;
      else if (accept) begin
        en_d    = '0;
        tgt_d   = req_sel;
        state_d = OFF_WAIT;
      end
    end else if (state_q == OFF_WAIT) begin
      if (!stuck || to) begin
        en_d    = N_CLK'(onehot(32'(tgt_q)));
        cur_d   = tgt_q;
        state_d = ON_WAIT;
      end
    end else if (!stuck) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end else if (to) state_d = ERR;
    cnt_d = (state_d != state_q || !waiting) ? '0 : cnt_q + 1'b1;
    err_d = to ? 1'b1 : err_clr ? 1'b0 : err_q;
  end

  // state registers; scan mode freezes everything except the synchroniser
  always_ff @(posedge clk) begin
    if (rst_clk) begin
      state_q <= ON_WAIT;
      en_q    <= N_CLK'(onehot(DEF_SEL));
      cur_q   <= SEL_W'(DEF_SEL);
      tgt_q   <= SEL_W'(DEF_SEL);
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (!dc_scan_mode) begin
      state_q <= state_d;
      en_q    <= en_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // at most one gate open, and gates only ever close-all or open-one
  a_onehot0: assert property (@(posedge clk) $onehot0(en_out));
  a_bbm: assert property (@(posedge clk) disable iff (rst_clk)
    (!$past(rst_clk) && en_out != $past(en_out)) |->
      (($past(en_out) == '0 && $onehot(en_out)) || ($onehot($past(en_out)) && en_out == '0)));
endmodule

// File: doc/clock_switch_ctrl.md
Name: clock_switch_ctrl

Overview:
- Parametrised N-source clock-switch sequencer running on one always-on control clock.
- Drives one-hot gate enables to per-domain enable synchronisers and ICGs.
- Enforces break-before-make: every currently-open gate must report closed before the new gate is opened.
- Successor to the fixed 3-clock switch; adds request handshake, ack tracking, timeout and error reporting.

Parameters:
- N_CLK, 3: number of selectable source clocks; legal range 2..8.
- SEL_W, 2: width of sel_req; must satisfy 2^SEL_W >= N_CLK.
- DEF_SEL, 0: source enabled out of reset.
- SYNC_STAGES, 2: flop stages on each en_ack bit; legal range 2..4.
- TIMEOUT, 64: control-clock cycles allowed per wait state.
- TO_W, 8: timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  control clock, always running.
- rst_clk  in  1  synchronous active-high reset.
- sel_req  in  SEL_W  requested source; any value >= N_CLK maps to N_CLK-1.
- sel_valid  in  1  request valid.
- sel_ready  out  1  request accepted on a cycle where sel_valid & sel_ready.
- en_out  out  N_CLK  registered gate enables, at most one bit high.
- en_ack  in  N_CLK  asynchronous per-domain "gate open" status.
- cur_sel  out  SEL_W  source currently selected or being brought up.
- busy  out  1  high while a switch is in progress.
- done  out  1  one-cycle pulse when a switch completes.
- timeout_err  out  1  sticky error flag.
- err_clr  in  1  clears timeout_err.
- dc_scan_mode  in  1  freeze input.

Behaviour:
- Ack synchronisation: en_ack is synchronised through SYNC_STAGES flops to form ack_s. Synchroniser flops reset to 0.
- Reset values: state=ON_WAIT, en_out=one-hot(DEF_SEL), cur_sel=DEF_SEL, busy=1, done=0, sel_ready=0, timeout_err=0, timeout counter=0.
- IDLE:
  - sel_ready=1, busy=0.
  - On accept with target==cur_sel: stay in IDLE, done=1 on the next cycle, en_out unchanged.
  - On accept with target!=cur_sel: next cycle en_out=0, tgt register loaded, state=OFF_WAIT, busy=1.
- OFF_WAIT:
  - Waits until all ack_s bits are 0.
  - Next cycle: en_out=one-hot(tgt), cur_sel=tgt, state=ON_WAIT.
- ON_WAIT:
  - Waits until ack_s[cur_sel]=1.
  - Next cycle: state=IDLE, busy=0, done=1 for exactly one cycle.
- Timeout counter:
  - Cleared on every state change.
  - Increments each cycle spent in OFF_WAIT or ON_WAIT.
  - Timeout fires when the count reaches TIMEOUT-1 while still waiting.
- Timeout in OFF_WAIT: set timeout_err, then proceed as if all acks were 0. The old gate is already commanded off, so a dead source clock cannot hang the switch.
- Timeout in ON_WAIT: set timeout_err, state=ERR, en_out held, busy=0, no done pulse.
- ERR:
  - sel_ready=1.
  - Accepting any request, including target==cur_sel, behaves like the IDLE target!=cur_sel path, so a retry restarts the sequence.
- timeout_err:
  - Cleared by err_clr.
  - If err_clr and a new timeout occur in the same cycle, the set wins.
- dc_scan_mode=1:
  - sel_ready=0.
  - FSM, timeout counter and all outputs hold their values.
  - Ack synchronisers keep sampling.
  - Resumes on the first cycle after dc_scan_mode returns to 0.
- rst_clk mid-switch: the reset values above apply unconditionally on the next edge. No request is remembered across reset.
- Worst-case accepted-to-done latency with ideal domains: 1 + (SYNC_STAGES + domain off delay) + 1 + (SYNC_STAGES + domain on delay) + 1 cycles.
- Invariant (assertion): $onehot0(en_out) every cycle.
- Invariant (assertion): en_out changes only from all-zero to one-hot, or from one-hot to all-zero.

Decomposition:
- Package clock_switch_pkg holds:
  - state enum IDLE/OFF_WAIT/ON_WAIT/ERR;
  - function sel_clamp(sel, N_CLK) implementing the >= N_CLK mapping;
  - function onehot(sel).
- One sub-module, clock_switch_sync_bus: a WIDTH x STAGES synchroniser with synchronous reset.

Test Plan:
- Bench domain model: en_ack = en_out delayed 3 cycles. Parameters N_CLK=3, SYNC_STAGES=2, TIMEOUT=64.
- Reset release: en_out=3'b001 immediately; busy=1 until done fires ~6 cycles later; cur_sel=0.
- Switch 0->2 via sel_req=2'b10:
  - en_out=000 the cycle after accept;
  - en_out=100 after ack_s all 0;
  - done pulse once; cur_sel=2; en_out never 011/101.
- sel_req=2'b11 with N_CLK=3: maps to source 2; cur_sel=2.
- Same-select request: accept sel_req=cur_sel in IDLE -> done next cycle, en_out unchanged, busy stays 0.
- Dead target: hold en_ack[1]=0 and request 1 -> after 64 cycles in ON_WAIT, state=ERR, timeout_err=1, no done. Then err_clr -> flag clears; retry with the ack model restored -> done.
- Freeze and reset:
  - Assert dc_scan_mode mid-OFF_WAIT for 20 cycles -> outputs frozen, sel_ready=0, no timeout; completes after release.
  - rst_clk mid-ON_WAIT -> en_out=001 next edge.
